// File: rtl/rca16_multiword_seq.sv
// rca16_multiword_seq
//   Performs (16*WORDS)-bit add or subtract by reusing a single 16-bit
//   ripple-carry adder slice once per cycle. Words are processed from the
//   least significant upward, and the carry is chained through a register.
//
// Ports
//   clk    : clock; all state updates on the rising edge
//   rst    : synchronous, active-high reset; abandons any operation in flight
//   start  : request pulse; accepted only while idle
//   sub    : 0 = a + b + cin, 1 = a - b (cin ignored)
//   a, b   : operands, latched together with start
//   cin    : carry-in for add mode, latched together with start
//   busy   : high while the word iteration is running
//   done   : one-cycle pulse when sum/cout/ovf hold a new result
//   sum    : registered full-width result
//   cout   : carry out of the most significant word (sub: 1 = no borrow)
//   ovf    : two's-complement overflow of the full-width result
module rca16_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W     = 16 * WORDS;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_acc;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_c_msb;

  logic [15:0]        w_a_word;
  logic [15:0]        w_b_word;
  logic [15:0]        w_slice;
  logic [16:0]        w_c;
  logic               w_last;

  // Operand word selection: idx*16 formed by concatenation.
  assign w_a_word = r_a[{r_idx, 4'b0000} +: 16];
  assign w_b_word = r_b[{r_idx, 4'b0000} +: 16];
  assign w_last   = (r_idx == IDX_W'(WORDS - 1));

  // Combinational 16-bit ripple-carry slice; w_c[15] is the carry into the
  // slice MSB and w_c[16] the carry out, both needed for overflow.
  always_comb begin
    w_slice = '0;
    w_c     = '0;
    w_c[0]  = r_carry;
    for (int i = 0; i < 16; i++) begin
      w_slice[i] = w_a_word[i] ^ w_b_word[i] ^ w_c[i];
      w_c[i+1]   = (w_a_word[i] & w_b_word[i]) |
                   (w_c[i] & (w_a_word[i] ^ w_b_word[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_c_msb <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        // Idle: latch operands; subtraction becomes a + ~b + 1.
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        // Run: one word per cycle, carry chained through r_carry.
        S_RUN: begin
          r_acc[{r_idx, 4'b0000} +: 16] <= w_slice;
          r_carry <= w_c[16];
          if (w_last) begin
            r_c_msb <= w_c[15];
            busy    <= 1'b0;
            r_state <= S_FIN;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        // Finish: publish result and flags for one done cycle.
        S_FIN: begin
          sum     <= r_acc;
          cout    <= r_carry;
          ovf     <= r_c_msb ^ r_carry;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca16_multiword_seq.sv
// Directed testbench for rca16_multiword_seq with WORDS=4 (64-bit operands).
module tb_rca16_multiword_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;
  localparam int TMO   = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  rca16_multiword_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges counted after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < TMO);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({busy, done, sum, cout, ovf} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy, done, sum, cout, ovf);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_word_carry();
    int n;
    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL t1_busy: got %b, required 1", busy);
    end
    wait_done(n);
    n_cmp++;
    if (n !== WORDS + 1) begin
      n_bad++; $display("FAIL t1_latency: got %0d edges, required %0d", n, WORDS + 1);
    end
    n_cmp++;
    if ({sum, cout, ovf} !== {64'h0000_0000_0001_0000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL t1_result: sum=%h cout=%b ovf=%b, required 0000000000010000 0 0",
               sum, cout, ovf);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL t1_busy_done: got %b, required 0", busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL t1_done_width: done still %b, required 0", done);
    end
    tick();
  endtask

  task automatic test_full_carry();
    int n;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_done(n);
    n_cmp++;
    if ({sum, cout, ovf} !== {64'h0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL t2_wrap: sum=%h cout=%b ovf=%b, required 0 1 0 (n=%0d)", sum, cout, ovf, n);
    end
    tick();
    issue(64'h0, 64'h0, 1'b1, 1'b0);
    wait_done(n);
    n_cmp++;
    if ({sum, cout} !== {64'h1, 1'b0}) begin
      n_bad++;
      $display("FAIL t2_cin: sum=%h cout=%b, required 1 0 (n=%0d)", sum, cout, n);
    end
    tick();
  endtask

  task automatic test_overflow();
    int n;
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_done(n);
    n_cmp++;
    if ({sum, cout, ovf} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL t3_add_ovf: sum=%h cout=%b ovf=%b, required 8000000000000000 0 1",
               sum, cout, ovf);
    end
    tick();
    issue(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
    wait_done(n);
    n_cmp++;
    if ({sum, cout, ovf} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL t3_sub_ovf: sum=%h cout=%b ovf=%b, required 7fffffffffffffff 1 1",
               sum, cout, ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    issue(64'h5, 64'h7, 1'b0, 1'b1);
    wait_done(n);
    n_cmp++;
    if ({sum, cout, ovf} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL t4_borrow: sum=%h cout=%b ovf=%b, required fffffffffffffffe 0 0",
               sum, cout, ovf);
    end
    // Issued during the done cycle.
    issue(64'h7, 64'h5, 1'b0, 1'b1);
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_bad++; $display("FAIL t4_accept: busy=%b done=%b, required 1 0", busy, done);
    end
    wait_done(n);
    n_cmp++;
    if (n !== WORDS + 1) begin
      n_bad++; $display("FAIL t4_latency: got %0d edges, required %0d", n, WORDS + 1);
    end
    n_cmp++;
    if ({sum, cout, ovf} !== {64'h2, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL t4_result: sum=%h cout=%b ovf=%b, required 2 1 0", sum, cout, ovf);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int n;
    int extra;
    issue(64'h1, 64'h1, 1'b0, 1'b0);
    tick();
    issue(64'h9, 64'h9, 1'b0, 1'b0);
    wait_done(n);
    n_cmp++;
    if (n !== WORDS - 1 || sum !== 64'h2) begin
      n_bad++;
      $display("FAIL t5_ignore: done after %0d edges sum=%h, required %0d edges sum 2",
               n, sum, WORDS - 1);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_bad++; $display("FAIL t5_queue: %0d busy/done cycles seen, required 0", extra);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    int extra;
    issue(64'h1234, 64'h1111, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, sum, cout, ovf} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL t6_abort: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy, done, sum, cout, ovf);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_bad++; $display("FAIL t6_no_done: %0d done pulses, required 0", extra);
    end
    issue(64'h3, 64'h4, 1'b0, 1'b0);
    wait_done(n);
    n_cmp++;
    if (n !== WORDS + 1 || sum !== 64'h7) begin
      n_bad++;
      $display("FAIL t6_recover: n=%0d sum=%h, required %0d and 7", n, sum, WORDS + 1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_word_carry();
    test_full_carry();
    test_overflow();
    test_back_to_back();
    test_start_while_busy();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rca16_multiword_seq.md
Name: rca16_multiword_seq

Overview:
- Sequencing controller that performs WORDS×16-bit add/subtract by reusing one 16-bit ripple-carry adder slice (RCA_16) once per cycle, least-significant word first, with carry chained through a register.
- Used where wide arithmetic is needed without replicating adder hardware; the controller owns operand latching, word indexing, carry chaining and result/flag registration.
- Start/busy/done handshake toward the issuing logic.

Parameters:
WORDS, 4, number of 16-bit words per operand; legal range 2..8; operand width = 16*WORDS.

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only when not busy
sub  input  1  0 = A+B+cin, 1 = A−B (cin ignored)
a  input  16*WORDS  operand A, sampled with start
b  input  16*WORDS  operand B, sampled with start
cin  input  1  carry-in for add mode, sampled with start
busy  output  1  high while a word iteration is in progress
done  output  1  one-cycle pulse when results are valid
sum  output  16*WORDS  registered result
cout  output  1  final carry out of the MSB word (sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow of the full-width result

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; operand, index, carry and accumulator registers=0. rst overrides start and any in-flight operation; the operation is abandoned with no done pulse.
- States: IDLE, RUN, FIN.
- IDLE: on start=1, latch a, b (inverted when sub=1) and the initial carry (sub ? 1 : cin). Set index=0, go to RUN, busy=1.
- RUN: each cycle the adder computes A[idx]+B'[idx]+carry.
  - Write the 16-bit slice into the accumulator at word idx; register the slice carry-out as the new carry.
  - On idx=WORDS−1, also capture the carry into bit 15 of that slice for overflow. Go to FIN.
  - Otherwise increment idx.
  - Exactly WORDS cycles are spent in RUN.
- FIN (one cycle): sum<=accumulator; cout<=final carry; ovf<=carry-into-MSB XOR carry-out-of-MSB; done=1 for this cycle; busy=0; go to IDLE.
- Latency: start sampled at edge T gives busy=1 from T through T+WORDS−1, and done=1 in the cycle following edge T+WORDS+1. WORDS=4: done is visible after the 6th edge counting T as edge 1.
- Outputs sum/cout/ovf hold their last values until the next FIN; they do not change during RUN.
- Handshake rules:
  - start while busy=1 is ignored (no queueing).
  - start in the same cycle as done is accepted; the controller re-enters RUN on the following edge, giving back-to-back operations with one idle-free FIN cycle between them.
- Width rules:
  - All arithmetic is modulo 2^(16*WORDS).
  - sub computes A + ~B + 1.
  - cout and ovf are defined on the full operand width, not per word.
- The adder slice is purely combinational inside the controller; no extra pipeline register exists between slice and accumulator.

Test Plan:
1. WORDS=4, a=0x0000_0000_0000_FFFF, b=0x1, cin=0, sub=0 -> sum=0x0000_0000_0001_0000, cout=0, ovf=0; done exactly one cycle, WORDS+1 cycles after RUN entry.
2. a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0, cout=1, ovf=0. Then a=0, b=0, cin=1 -> sum=0x1, cout=0.
3. a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, sub=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1. Then a=0x8000_0000_0000_0000, b=0x1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
4. sub=1, a=5, b=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then sub=1, a=7, b=5 issued in the done cycle -> accepted back-to-back; sum=0x2, cout=1.
5. start with a=1, b=1; pulse start again 2 cycles later with a=9, b=9 -> second pulse ignored; single done with sum=0x2.
6. rst asserted during RUN (idx=2) -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0, no done pulse. A subsequent start with a=3, b=4 completes normally with sum=0x7.
